// File: rtl/nbr_fetch.sv
// nbr_fetch: walks the radius-2 diamond around (cx,cy), reads 13 cost words, presents them as slots; WALL_MASK_EN masks all-ones words.
module nbr_fetch #(
  parameter int MAP_W  = 16,
  parameter int MAP_H  = 16,
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [XW-1:0]        cx,
  input  logic [YW-1:0]        cy,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_re,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic [13*DATA_W-1:0] slot_val,
  output logic [12:0]          slot_en
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int DX [13] = '{0, 0, 1, 0, -1, 0, 1, 2, 1, 0, -1, -2, -1};
  localparam int DY [13] = '{0, -1, 0, 1, 0, -2, -1, 0, 1, 2, 1, 0, -1};
  state_t state;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [3:0] idx, cap_idx, k_n;
  logic re_d, nxt_re, wall;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] val [13];
  int nx, ny;
  // Next slot's address is precomputed so ram_re/ram_addr can be registered
  always_comb begin
    k_n = (state == IDLE || idx == 4'd12) ? 4'd0 : idx + 4'd1;
    nx = int'(state == IDLE ? cx : x_q) + DX[k_n];
    ny = int'(state == IDLE ? cy : y_q) + DY[k_n];
    nxt_re = nx >= 0 && nx < MAP_W && ny >= 0 && ny < MAP_H;
    nxt_addr = ADDR_W'(ny * MAP_W + nx);
`ifdef WALL_MASK_EN
    wall = &ram_rdata;
`else
    wall = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cap_idx <= '0;
      re_d <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      ram_re <= 1'b0;
      ram_addr <= '0;
      slot_en <= '0;
      x_q <= '0;
      y_q <= '0;
      for (int i = 0; i < 13; i++) val[i] <= '1;
    end else begin
      re_d <= ram_re;
      cap_idx <= idx;
      if (re_d) begin
        slot_en[cap_idx] <= !wall;
        val[cap_idx] <= ram_rdata;
      end
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          busy <= 1'b1;
          x_q <= cx;
          y_q <= cy;
          idx <= '0;
          ram_re <= nxt_re;
          ram_addr <= nxt_addr;
          slot_en <= '0;
          for (int i = 0; i < 13; i++) val[i] <= '1;
        end
        ISSUE: if (idx == 4'd12) begin
          state <= DRAIN;
          ram_re <= 1'b0;
        end else begin
          idx <= idx + 4'd1;
          ram_re <= nxt_re;
          ram_addr <= nxt_addr;
        end
        DRAIN: begin
          state <= DONE;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end
  for (genvar g = 0; g < 13; g++) assign slot_val[g*DATA_W +: DATA_W] = val[g];
endmodule

// File: tb/tb_nbr_fetch.sv
// tb_nbr_fetch: directed checks of the nbr_fetch diamond walk against a behavioural cost RAM.
module tb_nbr_fetch;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] cx = 0, cy = 0;
  logic busy, done, ram_re;
  logic [7:0] ram_addr, ram_rdata;
  logic [103:0] slot_val;
  logic [12:0] slot_en;
  logic [7:0] mem [256];
  int passed = 0, total = 0;
  logic [15:0] re_mask, busy_mask;
  logic [7:0] addrs [13];
  int na, done_cnt, done_cyc, done_cyc2, re_cnt;
  logic [103:0] ev;
  int e55 [13] = '{85, 69, 86, 101, 84, 53, 70, 87, 102, 117, 100, 83, 68};
  int e00 [13] = '{0, -1, 1, 16, -1, -1, -1, 2, 17, 32, -1, -1, -1};
  int e157 [13] = '{127, 111, -1, 143, 126, 95, -1, -1, -1, 159, 142, 125, 110};

  nbr_fetch dut (.clk(clk), .rst(rst), .start(start), .cx(cx), .cy(cy), .busy(busy),
    .done(done), .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .slot_val(slot_val), .slot_en(slot_en));

  always #5 clk = ~clk;
  always_ff @(posedge clk) if (ram_re) ram_rdata <= mem[ram_addr];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic fetch(input logic [3:0] x, input logic [3:0] y);
    @(negedge clk); start = 1; cx = x; cy = y;
    @(negedge clk); start = 0;
    re_mask = 0; busy_mask = 0; done_cnt = 0; done_cyc = -1; na = 0;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) @(negedge clk);
      if (ram_re) begin
        re_mask[n] = 1'b1;
        if (na < 13) addrs[na] = ram_addr;
        na++;
      end
      if (done) begin done_cnt++; done_cyc = n; end
      busy_mask[n] = busy;
    end
  endtask

  function automatic logic [103:0] pack(input int e [13]);
    logic [103:0] v;
    for (int k = 0; k < 13; k++) v[k*8 +: 8] = e[k] < 0 ? 8'hFF : 8'(e[k]);
    return v;
  endfunction

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_en", slot_en, 0);
    chk("rst_val", slot_val, {104{1'b1}});
    rst = 0;

    fetch(5, 5);
    chk("c55_re_mask", re_mask, 16'h1FFF);
    for (int k = 0; k < 13; k++) chk($sformatf("c55_addr%0d", k + 1), addrs[k], 8'(e55[k]));
    chk("c55_busy", busy_mask, 16'h7FFF);
    chk("c55_done_cyc", done_cyc, 14);
    chk("c55_done_cnt", done_cnt, 1);
    chk("c55_en", slot_en, 13'h1FFF);
    chk("c55_val", slot_val, pack(e55));

    fetch(0, 0);
    chk("c00_re_mask", re_mask, 16'h038D);
    chk("c00_en", slot_en, 13'h038D);
    chk("c00_val", slot_val, pack(e00));
    chk("c00_done_cyc", done_cyc, 14);

    fetch(15, 7);
    chk("c157_re_mask", re_mask, 16'h1E3B);
    chk("c157_en", slot_en, 13'h1E3B);
    chk("c157_val", slot_val, pack(e157));

    @(negedge clk); start = 1; cx = 2; cy = 2;
    done_cnt = 0; done_cyc = -1; done_cyc2 = -1; re_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ram_re) re_cnt++;
      if (done) begin
        if (done_cnt == 0) done_cyc = n; else done_cyc2 = n;
        done_cnt++;
      end
      if (n == 18) start = 0;
    end
    chk("hold_done_cnt", done_cnt, 2);
    chk("hold_done1", done_cyc, 14);
    chk("hold_done2", done_cyc2, 30);
    chk("hold_re_cnt", re_cnt, 26);
    chk("hold_en", slot_en, 13'h1FFF);
    chk("hold_val1", slot_val[7:0], 8'd34);

    @(negedge clk); start = 1; cx = 5; cy = 5;
    @(negedge clk); start = 0;
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_re", ram_re, 0);
    chk("abort_en", slot_en, 0);
    chk("abort_done", done, 0);
    rst = 0;
    done_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("abort_idle", done_cnt, 0);
    fetch(5, 5);
    chk("after_done_cyc", done_cyc, 14);
    chk("after_en", slot_en, 13'h1FFF);
    chk("after_val", slot_val, pack(e55));

    mem[86] = 8'hFF;
    fetch(5, 5);
`ifdef WALL_MASK_EN
    chk("wall_en3", slot_en[2], 1'b0);
    chk("wall_en", slot_en, 13'h1FFB);
`else
    chk("wall_en3", slot_en[2], 1'b1);
    chk("wall_en", slot_en, 13'h1FFF);
`endif
    chk("wall_val3", slot_val[23:16], 8'hFF);
    chk("wall_done_cyc", done_cyc, 14);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
